// File: rtl/wrr_burst_arbiter.sv
// ============================================================================
// Module   : wrr_burst_arbiter
// Purpose  : Weighted round-robin arbiter for one beat-oriented shared
//            resource. A single requester holds the grant for a complete
//            multi-beat transfer, and may win up to its weight in consecutive
//            transfers before the grant rotates to the next requester.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req        - per-requester request, held for the whole transfer
//            req_last   - per-requester final-beat marker
//            cfg_weight - per-requester weight, W bits each (0 acts as 1)
//            rsc_ready  - resource accepts the current beat
//            gnt        - registered one-hot grant
//            gnt_valid  - registered |gnt
//            gnt_id     - index of the granted requester (held when idle)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrr_burst_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           req_last,
  input  logic [N*W-1:0]         cfg_weight,
  input  logic                   rsc_ready,
  output logic [N-1:0]           gnt,
  output logic                   gnt_valid,
  output logic [$clog2(N)-1:0]   gnt_id
);

  localparam int ID_W = $clog2(N);

  localparam logic [0:0]      S_IDLE  = 1'b0;
  localparam logic [0:0]      S_GRANT = 1'b1;

  localparam logic [ID_W:0]   C_N_EXT = (ID_W+1)'(N);
  localparam logic [N-1:0]    C_ONE   = N'(1);
  localparam logic [ID_W-1:0] C_LAST  = ID_W'(N-1);

  logic [0:0]      r_state;
  logic [W-1:0]    r_credit;
  logic [ID_W-1:0] r_last_id;
  logic [N-1:0]    r_gnt;
  logic            r_gnt_valid;
  logic [ID_W-1:0] r_gnt_id;

  logic            w_found;
  logic [ID_W-1:0] w_scan_id;
  logic [ID_W:0]   w_idx;
  logic            w_keep;
  logic [ID_W-1:0] w_win;
  logic [W-1:0]    w_wt_raw;
  logic [W-1:0]    w_wt_eff;
  logic            w_cur_req;
  logic            w_done;

  // Round-robin scan starting just after the previous winner. Offset N lands
  // back on last_id itself, so a lone requester with exhausted credit still
  // wins once nobody else is asking.
  always_comb begin
    w_found   = 1'b0;
    w_scan_id = r_last_id;
    w_idx     = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = {1'b0, r_last_id} + (ID_W+1)'(k);
      if (w_idx >= C_N_EXT) begin
        w_idx = w_idx - C_N_EXT;
      end
      if (!w_found && req[w_idx[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_scan_id = w_idx[ID_W-1:0];
      end
    end
  end

  // Previous winner keeps the resource while it still has credit and asks.
  assign w_keep   = (r_credit != '0) && req[r_last_id];
  assign w_win    = w_keep ? r_last_id : w_scan_id;
  assign w_wt_raw = cfg_weight[int'(w_win)*W +: W];
  assign w_wt_eff = (w_wt_raw == '0) ? W'(1) : w_wt_raw;

  // Only the granted requester's handshake matters during a transfer.
  assign w_cur_req = req[r_gnt_id];
  assign w_done    = w_cur_req & req_last[r_gnt_id] & rsc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_credit    <= '0;
      r_last_id   <= C_LAST;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state     <= S_GRANT;
            r_gnt       <= C_ONE << w_win;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_win;
            r_last_id   <= w_win;
            // Weight is sampled only when a fresh run of transfers begins.
            if (!w_keep) begin
              r_credit <= w_wt_eff;
            end
          end
        end
        S_GRANT: begin
          if (!w_cur_req) begin
            // Abort: drop the remaining credit so the grant rotates.
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_credit    <= '0;
          end else if (w_done) begin
            // Credit is at least 1 in GRANT, so this cannot underflow.
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_credit    <= r_credit - W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;

endmodule

`default_nettype wire

// File: tb/tb_wrr_burst_arbiter.sv
// ============================================================================
// Module   : tb_wrr_burst_arbiter
// Purpose  : Self-checking bench for wrr_burst_arbiter. Directed scenarios
//            plus randomized traffic, compared every cycle against a
//            behavioural reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wrr_burst_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] cfg_weight;
  logic           rsc_ready;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [1:0]     gnt_id;

  int total;
  int bad;

  // Reference model state: plain integers, arbitration expressed as rules.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_credit;

  bit prev_valid;
  int glog[$];

  wrr_burst_arbiter #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_last   (req_last),
    .cfg_weight (cfg_weight),
    .rsc_ready  (rsc_ready),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int weight_of(input int i);
    int w;
    w = int'(cfg_weight[i*W +: W]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    m_busy     = 1'b0;
    m_owner    = 0;
    m_last     = N - 1;
    m_credit   = 0;
    prev_valid = 1'b0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    int c;
    if (!m_busy) begin
      if (req != '0) begin
        if (m_credit > 0 && req[m_last]) begin
          m_owner = m_last;
        end else begin
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (req[c]) begin
              m_owner = c;
              break;
            end
          end
          m_credit = weight_of(m_owner);
        end
        m_last = m_owner;
        m_busy = 1'b1;
      end
    end else begin
      if (!req[m_owner]) begin
        m_busy   = 1'b0;
        m_credit = 0;
      end else if (rsc_ready && req_last[m_owner]) begin
        m_busy   = 1'b0;
        m_credit = m_credit - 1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
    check("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  // Inputs are set beforehand at a falling edge; outputs sampled at the next.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    if (gnt_valid && !prev_valid) glog.push_back(int'(gnt_id));
    prev_valid = gnt_valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_id", 32'(gnt_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    glog.delete();
  endtask

  task automatic check_order(input string tag, input int exp[], input int budget);
    int n;
    n = 0;
    while (glog.size() < exp.size() && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_count"}, 32'(glog.size() >= exp.size()), 32'h1);
    foreach (exp[i]) begin
      check(tag, (i < glog.size()) ? 32'(glog[i]) : 32'hffff_ffff, 32'(exp[i]));
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b1;
    req        = '0;
    req_last   = '0;
    cfg_weight = 16'h1111;
    rsc_ready  = 1'b1;
    model_reset();

    // Scenario 1: three-beat transfer from requester 0.
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    tick();
    req_last = 4'b0001;
    tick();
    check("s1_idle", 32'(gnt), 32'h0);
    req = '0;
    req_last = '0;
    tick();

    // Scenario 2: all requesting, weight 1, single-beat transfers.
    do_reset();
    req = 4'b1111;
    req_last = 4'b1111;
    check_order("s2_order", '{0, 1, 2, 3, 0}, 40);

    // Scenario 3: requester 0 has weight 2.
    do_reset();
    cfg_weight = 16'h1112;
    check_order("s3_order", '{0, 0, 1, 2, 3, 0, 0}, 60);
    cfg_weight = 16'h1111;

    // Scenario 4: stalled transfer on requester 1.
    do_reset();
    req = 4'b0010;
    req_last = 4'b0010;
    rsc_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("s4_held", 32'(gnt), 32'h2);
    rsc_ready = 1'b1;
    tick();
    check("s4_drop", 32'(gnt), 32'h0);
    req = '0;
    req_last = '0;
    tick();

    // Scenario 5: abort by requester 0 with requester 2 pending.
    do_reset();
    req = 4'b0101;
    tick();
    tick();
    tick();
    req = 4'b0100;
    tick();
    check("s5_gap", 32'(gnt_valid), 32'h0);
    tick();
    check("s5_next", 32'(gnt_id), 32'h2);
    req = '0;
    tick();
    tick();

    // Scenario 6: reset in the middle of requester 3's grant.
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    do_reset();
    tick();
    check("s6_regrant", 32'(gnt_id), 32'h3);
    req = 4'b1111;
    req_last = 4'b1111;
    check_order("s6_order", '{3, 0, 1}, 20);

    // Randomized traffic with sticky requests and occasional resets.
    do_reset();
    req = '0;
    req_last = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      req_last  = N'($urandom);
      rsc_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) cfg_weight = (N*W)'($urandom) & 16'h3333;
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
